// File: rtl/keypad_lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// keypad_lock_ctrl_if
//
// Bundles the key-strobe input and the status outputs of the keypad lock
// session sequencer.
//
//   key_valid  one-cycle strobe, one per keypress (driven by master)
//   key_code   4-bit key code: 0..9 digit, 'hA CLEAR, 'hB PROG (master)
//   unlock     high while the lock is open (slave)
//   fail_led   high while a failed attempt is indicated (slave)
//   locked     high during lockout (slave)
//   prog_mode  high while a new password is being entered (slave)
//   digit_cnt  digits accepted in the current entry/programming session
//   fail_cnt   consecutive failed attempts
//
// master: the keyboard front end / test driver.
// slave : keypad_lock_ctrl.
// ---------------------------------------------------------------------------
interface keypad_lock_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       unlock;
    logic       fail_led;
    logic       locked;
    logic       prog_mode;
    logic [2:0] digit_cnt;
    logic [2:0] fail_cnt;

    modport master (
        output key_valid,
        output key_code,
        input  unlock,
        input  fail_led,
        input  locked,
        input  prog_mode,
        input  digit_cnt,
        input  fail_cnt
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output unlock,
        output fail_led,
        output locked,
        output prog_mode,
        output digit_cnt,
        output fail_cnt
    );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_lock_ctrl
//
// Session sequencer for the keypad lock. Collects digit keys, compares them
// against a programmable password, counts consecutive failures, enforces a
// lockout after too many failures and lets the password be reprogrammed
// while the lock is open.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (also restores DEFAULT_PW)
//   bus    keypad_lock_ctrl_if.slave: key strobe/code in, status out
//
// Parameters:
//   DIGITS          password length in digits (2..8)
//   DEFAULT_PW      reset password, first digit in the MS nibble
//   MAX_FAIL        consecutive failures that trigger lockout (1..7)
//   HOLD_CYCLES     length of the OPEN and FAIL indications
//   TIMEOUT_CYCLES  idle-cycle limit between keys in ENTRY/PROG
//   LOCK_CYCLES     lockout length
//
// All outputs are decodes of registered state and counters.
// ---------------------------------------------------------------------------
module keypad_lock_ctrl #(
    parameter int                   DIGITS         = 4,
    parameter logic [DIGITS*4-1:0]  DEFAULT_PW     = 16'h1234,
    parameter int                   MAX_FAIL       = 3,
    parameter int                   HOLD_CYCLES    = 200,
    parameter int                   TIMEOUT_CYCLES = 500,
    parameter int                   LOCK_CYCLES    = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    keypad_lock_ctrl_if.slave  bus
);

    localparam int PW_W  = DIGITS * 4;

    // One shared timer serves every timed state, so it is sized for the
    // longest of the three limits.
    localparam int T_HT  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int T_MAX = (T_HT > LOCK_CYCLES) ? T_HT : LOCK_CYCLES;
    localparam int TMR_W = $clog2(T_MAX + 1);

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);

    localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;
    localparam logic [2:0] S_PROG    = 3'd5;

    localparam logic [3:0] K_CLEAR = 4'hA;
    localparam logic [3:0] K_PROG  = 4'hB;

    // Failure counter never wraps; it stops at MAX_FAIL.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= MAX_FAIL_C) ? v : v + 3'd1;
    endfunction

    logic [2:0]       r_state;
    logic [PW_W-1:0]  r_pw;
    logic [PW_W-1:0]  r_shadow;
    logic [2:0]       r_digit_cnt;
    logic [2:0]       r_fail_cnt;
    logic             r_mismatch;
    logic [TMR_W-1:0] r_timer;

    logic [2:0]       w_state_n;
    logic [PW_W-1:0]  w_pw_n;
    logic [PW_W-1:0]  w_shadow_n;
    logic [2:0]       w_digit_cnt_n;
    logic [2:0]       w_fail_cnt_n;
    logic             w_mismatch_n;
    logic             w_timer_clr;

    logic             w_is_digit;
    logic             w_is_clear;
    logic             w_is_prog;
    logic [PW_W-1:0]  w_pw_aligned;
    logic [3:0]       w_exp_nib;
    logic             w_mis_now;
    logic [PW_W-1:0]  w_shift_in;

    assign w_is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign w_is_clear = bus.key_valid && (bus.key_code == K_CLEAR);
    assign w_is_prog  = bus.key_valid && (bus.key_code == K_PROG);

    // The expected digit is nibble digit_cnt counted from the MS end; shifting
    // it to the top avoids a variable-base part-select. digit_cnt is 0 in
    // IDLE, so the same path serves the first digit.
    assign w_pw_aligned = r_pw << {r_digit_cnt, 2'b00};
    assign w_exp_nib    = w_pw_aligned[PW_W-1 -: 4];
    assign w_mis_now    = r_mismatch | (bus.key_code != w_exp_nib);

    // Programming digits enter at the LS end so the first one ends up MS.
    assign w_shift_in   = {r_shadow[PW_W-5:0], bus.key_code};

    always_comb begin
        w_state_n     = r_state;
        w_pw_n        = r_pw;
        w_shadow_n    = r_shadow;
        w_digit_cnt_n = r_digit_cnt;
        w_fail_cnt_n  = r_fail_cnt;
        w_mismatch_n  = r_mismatch;
        w_timer_clr   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_is_digit) begin
                    w_mismatch_n  = w_mis_now;
                    w_digit_cnt_n = 3'd1;
                    w_state_n     = S_ENTRY;
                end
            end

            S_ENTRY: begin
                // A key on the expiry edge is processed, so digits are
                // checked ahead of the timeout.
                if (w_is_digit) begin
                    if (r_digit_cnt == LAST_DIGIT) begin
                        w_digit_cnt_n = 3'd0;
                        w_mismatch_n  = 1'b0;
                        if (w_mis_now) begin
                            w_state_n    = S_FAIL;
                            w_fail_cnt_n = sat_inc(r_fail_cnt);
                        end else begin
                            w_state_n    = S_OPEN;
                            w_fail_cnt_n = 3'd0;
                        end
                    end else begin
                        w_digit_cnt_n = r_digit_cnt + 3'd1;
                        w_mismatch_n  = w_mis_now;
                        w_timer_clr   = 1'b1;
                    end
                end else if (w_is_clear) begin
                    w_state_n = S_IDLE;
                end else if (r_timer == TO_LAST) begin
                    w_state_n = S_IDLE;
                end
            end

            S_OPEN: begin
                if (w_is_clear) begin
                    w_state_n = S_IDLE;
                end else if (w_is_prog) begin
                    w_state_n     = S_PROG;
                    w_digit_cnt_n = 3'd0;
                    w_shadow_n    = '0;
                end else if (r_timer == HOLD_LAST) begin
                    w_state_n = S_IDLE;
                end
            end

            S_FAIL: begin
                if (r_timer == HOLD_LAST) begin
                    w_state_n = (r_fail_cnt == MAX_FAIL_C) ? S_LOCKOUT : S_IDLE;
                end
            end

            S_LOCKOUT: begin
                if (r_timer == LOCK_LAST) begin
                    w_fail_cnt_n = 3'd0;
                    w_state_n    = S_IDLE;
                end
            end

            S_PROG: begin
                if (w_is_digit) begin
                    if (r_digit_cnt == LAST_DIGIT) begin
                        w_pw_n    = w_shift_in;
                        w_state_n = S_IDLE;
                    end else begin
                        w_shadow_n    = w_shift_in;
                        w_digit_cnt_n = r_digit_cnt + 3'd1;
                        w_timer_clr   = 1'b1;
                    end
                end else if (w_is_clear) begin
                    w_state_n = S_IDLE;
                end else if (r_timer == TO_LAST) begin
                    w_state_n = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Every session starts from a clean slate.
        if (w_state_n == S_IDLE) begin
            w_digit_cnt_n = 3'd0;
            w_mismatch_n  = 1'b0;
            w_shadow_n    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pw        <= DEFAULT_PW;
            r_shadow    <= '0;
            r_digit_cnt <= 3'd0;
            r_fail_cnt  <= 3'd0;
            r_mismatch  <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_pw        <= w_pw_n;
            r_shadow    <= w_shadow_n;
            r_digit_cnt <= w_digit_cnt_n;
            r_fail_cnt  <= w_fail_cnt_n;
            r_mismatch  <= w_mismatch_n;
            // Timer restarts on any state change or accepted key; it idles
            // at zero in IDLE since nothing there is timed.
            if ((w_state_n != r_state) || w_timer_clr) begin
                r_timer <= '0;
            end else if (r_state != S_IDLE) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign bus.unlock    = (r_state == S_OPEN);
    assign bus.fail_led  = (r_state == S_FAIL);
    assign bus.locked    = (r_state == S_LOCKOUT);
    assign bus.prog_mode = (r_state == S_PROG);
    assign bus.digit_cnt = ((r_state == S_ENTRY) || (r_state == S_PROG)) ? r_digit_cnt : 3'd0;
    assign bus.fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_lock_ctrl
//
// Directed bench for keypad_lock_ctrl. A session model (entered-digit queue,
// digit array password, countdown of remaining cycles) predicts every output
// each cycle; literal checks pin key moments and indication lengths.
// ---------------------------------------------------------------------------
module tb_keypad_lock_ctrl;

    localparam int DIGITS   = 4;
    localparam int HOLD     = 8;
    localparam int TIMEOUT  = 16;
    localparam int LOCK     = 32;
    localparam int MAX_FAIL = 3;

    logic clk;
    logic rst_n;

    keypad_lock_ctrl_if bus();

    keypad_lock_ctrl #(
        .DIGITS         (DIGITS),
        .DEFAULT_PW     (16'h1234),
        .MAX_FAIL       (MAX_FAIL),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT),
        .LOCK_CYCLES    (LOCK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- session model ----------------
    typedef enum int {MD_IDLE, MD_ENTRY, MD_OPEN, MD_FAIL, MD_LOCK, MD_PROG} mode_t;

    mode_t m_mode;
    int    m_pw [DIGITS];
    int    m_entered [$];
    int    m_left;
    int    m_fails;

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_pw[0] = 1; m_pw[1] = 2; m_pw[2] = 3; m_pw[3] = 4;
        m_entered.delete();
        m_left  = 0;
        m_fails = 0;
    endtask

    task automatic go_idle();
        m_mode = MD_IDLE;
        m_entered.delete();
    endtask

    // Advance the model by one clock edge with the key seen on that edge.
    task automatic model_step(input logic v, input logic [3:0] c);
        bit dig, clr, prg, ok;
        dig = v && (c <= 4'd9);
        clr = v && (c == 4'hA);
        prg = v && (c == 4'hB);
        case (m_mode)
            MD_IDLE: begin
                if (dig) begin
                    m_entered.delete();
                    m_entered.push_back(int'(c));
                    m_mode = MD_ENTRY;
                    m_left = TIMEOUT;
                end
            end
            MD_ENTRY: begin
                if (dig) begin
                    m_entered.push_back(int'(c));
                    if (m_entered.size() == DIGITS) begin
                        ok = 1'b1;
                        for (int i = 0; i < DIGITS; i++)
                            if (m_entered[i] != m_pw[i]) ok = 1'b0;
                        m_entered.delete();
                        m_left = HOLD;
                        if (ok) begin
                            m_mode  = MD_OPEN;
                            m_fails = 0;
                        end else begin
                            m_mode  = MD_FAIL;
                            m_fails = (m_fails < MAX_FAIL) ? m_fails + 1 : m_fails;
                        end
                    end else begin
                        m_left = TIMEOUT;
                    end
                end else if (clr) begin
                    go_idle();
                end else begin
                    m_left--;
                    if (m_left == 0) go_idle();
                end
            end
            MD_OPEN: begin
                if (clr) begin
                    go_idle();
                end else if (prg) begin
                    m_mode = MD_PROG;
                    m_entered.delete();
                    m_left = TIMEOUT;
                end else begin
                    m_left--;
                    if (m_left == 0) go_idle();
                end
            end
            MD_FAIL: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_fails == MAX_FAIL) begin
                        m_mode = MD_LOCK;
                        m_left = LOCK;
                    end else begin
                        go_idle();
                    end
                end
            end
            MD_LOCK: begin
                m_left--;
                if (m_left == 0) begin
                    m_fails = 0;
                    go_idle();
                end
            end
            MD_PROG: begin
                if (dig) begin
                    m_entered.push_back(int'(c));
                    if (m_entered.size() == DIGITS) begin
                        for (int i = 0; i < DIGITS; i++) m_pw[i] = m_entered[i];
                        go_idle();
                    end else begin
                        m_left = TIMEOUT;
                    end
                end else if (clr) begin
                    go_idle();
                end else begin
                    m_left--;
                    if (m_left == 0) go_idle();
                end
            end
            default: go_idle();
        endcase
    endtask

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    int hi_unlock = 0;
    int hi_fail   = 0;
    int hi_lock   = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("unlock",    int'(bus.unlock),    (m_mode == MD_OPEN) ? 1 : 0);
            check("fail_led",  int'(bus.fail_led),  (m_mode == MD_FAIL) ? 1 : 0);
            check("locked",    int'(bus.locked),    (m_mode == MD_LOCK) ? 1 : 0);
            check("prog_mode", int'(bus.prog_mode), (m_mode == MD_PROG) ? 1 : 0);
            check("digit_cnt", int'(bus.digit_cnt),
                  (m_mode == MD_ENTRY || m_mode == MD_PROG) ? m_entered.size() : 0);
            check("fail_cnt",  int'(bus.fail_cnt),  m_fails);
            hi_unlock += int'(bus.unlock);
            hi_fail   += int'(bus.fail_led);
            hi_lock   += int'(bus.locked);
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge: present a key, take the next edge,
    // then advance the model with what that edge sampled.
    task automatic cyc(input logic v, input logic [3:0] c);
        bus.key_valid = v;
        bus.key_code  = c;
        @(posedge clk);
        #1;
        model_step(v, c);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic key(input logic [3:0] c);
        cyc(1'b1, c);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'h0);
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_unlock"},    int'(bus.unlock),    0);
        check({tag, "_fail_led"},  int'(bus.fail_led),  0);
        check({tag, "_locked"},    int'(bus.locked),    0);
        check({tag, "_prog_mode"}, int'(bus.prog_mode), 0);
        check({tag, "_digit_cnt"}, int'(bus.digit_cnt), 0);
        check({tag, "_fail_cnt"},  int'(bus.fail_cnt),  0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Correct entry with the default password.
        key(4'd1); key(4'd2); key(4'd3);
        check("entry_digit_cnt3", int'(bus.digit_cnt), 3);
        key(4'd4);
        check("open_unlock_rise", int'(bus.unlock), 1);
        check("open_fail_cnt",    int'(bus.fail_cnt), 0);
        hi_unlock = 0;
        idle(10);
        check("open_length", hi_unlock, 8);

        // Wrong entry: no early reject, full length collected.
        key(4'd1); key(4'd2); key(4'd5);
        check("wrong_digit_cnt3", int'(bus.digit_cnt), 3);
        key(4'd4);
        check("wrong_fail_led", int'(bus.fail_led), 1);
        check("wrong_fail_cnt", int'(bus.fail_cnt), 1);
        hi_fail = 0;
        idle(10);
        check("fail_length", hi_fail, 8);

        // Two more failures -> lockout; keys during lockout are ignored.
        enter4(4'd1, 4'd2, 4'd5, 4'd4);
        idle(8);
        enter4(4'd1, 4'd2, 4'd5, 4'd4);
        check("third_fail_cnt", int'(bus.fail_cnt), 3);
        idle(8);
        check("lockout_entered", int'(bus.locked), 1);
        hi_lock = 0;
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("lockout_ignores_keys", int'(bus.unlock), 0);
        idle(40);
        check("lockout_length", hi_lock, 32);
        check("lockout_fail_cnt_clr", int'(bus.fail_cnt), 0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("post_lock_unlock", int'(bus.unlock), 1);
        idle(10);

        // Timeout with a nonzero failure count.
        enter4(4'd9, 4'd9, 4'd9, 4'd9);
        idle(8);
        key(4'd1); key(4'd2);
        idle(15);
        check("timeout_not_yet", int'(bus.digit_cnt), 2);
        idle(1);
        check("timeout_digit_cnt", int'(bus.digit_cnt), 0);
        check("timeout_fail_cnt",  int'(bus.fail_cnt), 1);

        // Key arriving at timer count 15 is accepted.
        key(4'd1); key(4'd2);
        idle(15);
        key(4'd3);
        check("late_key_accepted", int'(bus.digit_cnt), 3);
        key(4'd4);
        check("late_key_unlock", int'(bus.unlock), 1);
        idle(10);

        // CLEAR mid-entry: no failure counted.
        key(4'd1); key(4'd7);
        key(4'hA);
        check("clear_digit_cnt", int'(bus.digit_cnt), 0);
        check("clear_fail_cnt",  int'(bus.fail_cnt), 0);
        idle(3);

        // Program a new password 9876.
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        key(4'hB);
        check("prog_enter", int'(bus.prog_mode), 1);
        key(4'd9); key(4'd8); key(4'd7);
        check("prog_digit_cnt3", int'(bus.digit_cnt), 3);
        key(4'd6);
        check("prog_commit_exit", int'(bus.prog_mode), 0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("old_pw_fails", int'(bus.fail_led), 1);
        idle(8);
        enter4(4'd9, 4'd8, 4'd7, 4'd6);
        check("new_pw_unlocks", int'(bus.unlock), 1);

        // Aborted programming keeps the password.
        key(4'hB); key(4'd5); key(4'hA);
        check("prog_abort_exit", int'(bus.prog_mode), 0);
        idle(2);
        enter4(4'd9, 4'd8, 4'd7, 4'd6);
        check("pw_unchanged", int'(bus.unlock), 1);
        key(4'hA);
        check("clear_relocks", int'(bus.unlock), 0);
        idle(2);

        // Reset mid-entry after a failure.
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        idle(8);
        key(4'd9); key(4'd8); key(4'd7);
        check("pre_reset_digit_cnt", int'(bus.digit_cnt), 3);
        check("pre_reset_fail_cnt",  int'(bus.fail_cnt), 1);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("post_reset_default_pw", int'(bus.unlock), 1);
        idle(10);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Session sequencer for the keypad lock. It consumes debounced key strobes from the keyboard front end and runs each entry attempt: collecting digits, comparing them against a programmable password, counting failures, and enforcing a lockout. It drives the unlock/fail/locked LEDs and allows the password to be reprogrammed while the lock is open.

## Interface
- DIGITS, 4: password length in digits, legal range 2..8.
- DEFAULT_PW, 16'h1234: reset password, 4 bits per digit, first digit in the MS nibble; width DIGITS*4.
- MAX_FAIL, 3: consecutive failures that trigger lockout, range 1..7.
- HOLD_CYCLES, 200: duration of the OPEN and FAIL indications.
- TIMEOUT_CYCLES, 500: idle-cycle limit between keys in ENTRY/PROG.
- LOCK_CYCLES, 1000: lockout duration.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_valid  in  1  one-cycle strobe, one per keypress.
- key_code  in  4  0..9 digit; 'hA CLEAR; 'hB PROG; other codes ignored.
- unlock  out  1  high in OPEN.
- fail_led  out  1  high in FAIL.
- locked  out  1  high in LOCKOUT.
- prog_mode  out  1  high in PROG.
- digit_cnt  out  3  digits accepted in the current ENTRY/PROG session; 0 in all other states.
- fail_cnt  out  3  consecutive failures.

## Operation
- States: IDLE, ENTRY, OPEN, FAIL, LOCKOUT, PROG.
- Outputs are Moore decodes of registered state/counters. There are no glitches.
- Reset: state IDLE, password register = DEFAULT_PW, digit_cnt 0, fail_cnt 0, mismatch 0, timer 0. All outputs 0.
- IDLE:
  - Digit: compare against nibble 0, set mismatch on inequality, digit_cnt=1, go to ENTRY.
  - CLEAR, PROG, and other codes: ignored.
- ENTRY:
  - Digit i (0-based) is compared to nibble i and ORed into mismatch. There is no early reject; all DIGITS digits are always collected.
  - On digit DIGITS-1, evaluate with that digit included:
    - Match: go to OPEN, fail_cnt=0.
    - Otherwise: go to FAIL, fail_cnt+1.
  - CLEAR: go to IDLE, no failure counted.
  - PROG: ignored.
- OPEN:
  - Hold for HOLD_CYCLES, then go to IDLE.
  - CLEAR: go to IDLE immediately (relock).
  - PROG: go to PROG, digit_cnt=0.
  - Digits: ignored.
- FAIL:
  - Hold for HOLD_CYCLES, all keys ignored.
  - Then go to LOCKOUT if fail_cnt==MAX_FAIL, else go to IDLE.
- LOCKOUT:
  - All keys ignored for LOCK_CYCLES.
  - Then fail_cnt=0 and go to IDLE.
- PROG:
  - Digits shift into a shadow register, first digit in the MS nibble.
  - On digit DIGITS, commit the shadow register to the password register and go to IDLE.
  - CLEAR or timeout: go to IDLE, password unchanged.
- Per-session state (mismatch, digit_cnt, shadow) is cleared on every entry to IDLE.
- fail_cnt saturates at MAX_FAIL. It persists across IDLE and is cleared only by OPEN, the end of LOCKOUT, or reset.

## Timing
- key_valid is sampled on the rising edge. Every state change takes effect on the same edge.
- An output changes in the cycle after the sampling edge:
  - unlock rises the cycle after the edge that samples the final correct digit.
  - fail_led likewise rises the cycle after the edge sampling a wrong final digit.
- Indication durations:
  - unlock stays high exactly HOLD_CYCLES cycles unless cut short by CLEAR/PROG.
  - fail_led stays high exactly HOLD_CYCLES cycles.
  - locked stays high exactly LOCK_CYCLES cycles.
- Timer: a single counter, zeroed on every state change and on every accepted key in ENTRY/PROG.
  - Expiry occurs when the count reaches (limit-1).
  - The transition happens on that edge.
- Key coincident with timeout expiry: the key wins. It is processed and the timer restarts.
- Ignored keys do not reset the timer.
- Back-to-back key_valid on consecutive cycles are each accepted; no minimum spacing.
- rst_n asserted mid-operation forces the reset state immediately. The password reverts to DEFAULT_PW.

## Test plan
Use DIGITS=4, HOLD=8, TIMEOUT=16, LOCK=32, MAX_FAIL=3.

- Correct entry: after reset, keys 1,2,3,4 -> unlock=1 for exactly 8 cycles starting the cycle after the key 4 edge; fail_cnt=0; then IDLE.
- Wrong entry: keys 1,2,5,4 -> no early reject, digit_cnt reaches 3; fail_led=1 for 8 cycles; fail_cnt=1; then IDLE.
- Lockout: three wrong entries -> locked=1 for 32 cycles; keys 1,2,3,4 pressed during lockout are ignored; fail_cnt=0 afterward; then 1,2,3,4 unlocks.
- Timeout and CLEAR:
  - Keys 1,2 then 16 idle cycles -> IDLE with digit_cnt=0 and fail_cnt unchanged.
  - A key arriving at timer count 15 is accepted.
  - CLEAR mid-entry -> IDLE with no failure counted.
- Programming:
  - Unlock, PROG, 9,8,7,6 -> prog_mode drops; 1,2,3,4 now fails; 9,8,7,6 unlocks.
  - PROG, 5, CLEAR -> password unchanged.
- Reset mid-operation: program 9876, enter 9,8,7, then assert rst_n -> all outputs 0, fail_cnt=0; afterward 1,2,3,4 unlocks.
